// File: rtl/rx_pkg.sv
// rx_pkg: shared widths and packer state for the RGMII receive payload path
package rx_pkg;
    localparam int AW = 14;
    localparam int WW = 32;
    localparam int NLANE = 4;
    typedef enum logic {IDLE, ACC} pack_st_e;
endpackage

// File: rtl/byte_packer.sv
// byte_packer: packs byte-addressed writes into little-endian words, flushing on lane 3, word change or request
module byte_packer import rx_pkg::*; #(
    parameter int AW = rx_pkg::AW,
    parameter int WW = rx_pkg::WW
) (
    input  logic             rxclk,
    input  logic             rst_n,
    input  logic             i_wr,
    input  logic [AW-1:0]    i_addr,
    input  logic [7:0]       i_byte,
    input  logic             i_flush,
    output logic             o_we,
    output logic [AW-3:0]    o_waddr,
    output logic [WW-1:0]    o_wdata,
    output logic [NLANE-1:0] o_be
);
    pack_st_e         r_st, w_st;
    logic [AW-3:0]    r_wa, w_wa_in;
    logic [WW-1:0]    r_word, w_word;
    logic [NLANE-1:0] r_pbe, w_pbe;
    logic [1:0]       w_lane;
    logic             w_old, w_full;

    // An old-word flush wins the write port; a lane-3 byte arriving with it stays pending.
    always_comb begin
        w_lane = i_addr[1:0];
        w_wa_in = i_addr[AW-1:2];
        w_old = (r_st == ACC) && (i_flush || (i_wr && w_wa_in != r_wa));
        w_word = (w_old || r_st == IDLE) ? '0 : r_word;
        w_pbe = (w_old || r_st == IDLE) ? '0 : r_pbe;
        if (i_wr) begin
            w_word[{w_lane, 3'b000} +: 8] = i_byte;
            w_pbe[w_lane] = 1'b1;
        end
        w_full = i_wr && !w_old && w_lane == 2'd3;
        w_st = w_full ? IDLE : i_wr ? ACC : w_old ? IDLE : r_st;
    end

    always_ff @(posedge rxclk) begin
        if (!rst_n) begin
            r_st <= IDLE;
            r_wa <= '0;
            r_word <= '0;
            r_pbe <= '0;
            o_we <= 1'b0;
            o_waddr <= '0;
            o_wdata <= '0;
            o_be <= '0;
        end else begin
            r_st <= w_st;
            r_wa <= i_wr ? w_wa_in : r_wa;
            r_word <= w_word;
            r_pbe <= w_full ? '0 : w_pbe;
            o_we <= w_old || w_full;
            if (w_old || w_full) begin
                o_waddr <= w_old ? r_wa : w_wa_in;
                o_wdata <= w_old ? r_word : w_word;
                o_be <= w_old ? r_pbe : w_pbe;
            end
        end
    end
endmodule

// File: rtl/rx_payload_writer.sv
// rx_payload_writer: segment tracking, length/contiguity checks and byte counting in front of the word packer
module rx_payload_writer import rx_pkg::*; #(
    parameter int AW = rx_pkg::AW,
    parameter int WW = rx_pkg::WW
) (
    input  logic             rxclk,
    input  logic             rst_n,
    input  logic [7:0]       din,
    input  logic             din_vld,
    input  logic [AW-1:0]    addr,
    input  logic [AW-1:0]    cycle,
    output logic             mem_we,
    output logic [AW-3:0]    mem_waddr,
    output logic [WW-1:0]    mem_wdata,
    output logic [NLANE-1:0] mem_be,
    output logic             frame_done,
    output logic [AW-1:0]    byte_cnt,
    output logic             err_gap,
    output logic             err_ovf
);
    logic          r_vld_d, r_have;
    logic [AW-1:0] r_len, r_exp;
    logic [AW-1:0] w_len, w_cnt1;
    logic          w_start, w_acc, w_gap, w_fall, w_hit;

    always_comb begin
        w_start = din_vld && !r_vld_d;
        w_len = w_start ? cycle : r_len;
        w_acc = din_vld && addr < w_len;
        w_gap = w_acc && !w_start && r_have && addr != r_exp;
        w_fall = r_vld_d && !din_vld;
        w_cnt1 = byte_cnt + 1'b1;
        w_hit = w_acc && w_cnt1 == w_len;
    end

    always_ff @(posedge rxclk) begin
        if (!rst_n) begin
            r_vld_d <= 1'b0;
            r_have <= 1'b0;
            r_len <= '0;
            r_exp <= '0;
            frame_done <= 1'b0;
            byte_cnt <= '0;
            err_gap <= 1'b0;
            err_ovf <= 1'b0;
        end else begin
            r_vld_d <= din_vld;
            r_have <= w_acc || (r_have && !w_start);
            r_len <= w_len;
            r_exp <= w_acc ? addr + 1'b1 : r_exp;
            frame_done <= w_hit;
            byte_cnt <= w_hit ? '0 : w_acc ? w_cnt1 : byte_cnt;
            err_gap <= err_gap || w_gap;
            err_ovf <= err_ovf || (din_vld && !w_acc);
        end
    end

    byte_packer #(.AW(AW), .WW(WW)) u_packer (
        .rxclk(rxclk),
        .rst_n(rst_n),
        .i_wr(w_acc),
        .i_addr(addr),
        .i_byte(din),
        .i_flush(w_gap || w_fall),
        .o_we(mem_we),
        .o_waddr(mem_waddr),
        .o_wdata(mem_wdata),
        .o_be(mem_be)
    );
endmodule

// File: tb/tb_rx_payload_writer.sv
// tb_rx_payload_writer: table-driven segments with a write scoreboard, plus timing and mid-word reset sequences
module tb_rx_payload_writer;
    logic        rxclk = 1'b0, rst_n = 1'b0, din_vld = 1'b0;
    logic [7:0]  din = '0;
    logic [13:0] addr = '0, cycle = '0;
    logic        mem_we, frame_done, err_gap, err_ovf;
    logic [11:0] mem_waddr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [13:0] byte_cnt;
    int total = 0, bad = 0, n_done = 0;

    typedef struct {int wa; int be;} wr_t;
    typedef struct {
        int cyc, a0, n, k, j, nw;
        int wa0, be0, wa1, be1, wa2, be2;
        int done, gap, ovf, cnt;
    } vec_t;
    wr_t q[$];

    rx_payload_writer dut (
        .rxclk(rxclk), .rst_n(rst_n), .din(din), .din_vld(din_vld), .addr(addr), .cycle(cycle),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .frame_done(frame_done), .byte_cnt(byte_cnt), .err_gap(err_gap), .err_ovf(err_ovf)
    );

    always #5 rxclk = ~rxclk;

    function automatic logic [7:0] byte_of(input logic [13:0] a);
        return a[7:0] ^ 8'h5A;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge rxclk) begin
        wr_t e;
        logic [31:0] m, x;
        if (frame_done) n_done++;
        if (mem_we) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got waddr=%0h be=%0h expected no write", mem_waddr, mem_be);
            end else begin
                e = q.pop_front();
                for (int l = 0; l < 4; l++) begin
                    m[8*l +: 8] = e.be[l] ? 8'hFF : 8'h00;
                    x[8*l +: 8] = byte_of({e.wa[11:0], l[1:0]});
                end
                chk("waddr", {20'd0, mem_waddr}, e.wa);
                chk("be", {28'd0, mem_be}, e.be);
                chk("wdata", mem_wdata & m, x & m);
            end
        end
    end

    task automatic chk_rst(input string p);
        chk({p, "_we"}, {31'd0, mem_we}, 0);
        chk({p, "_waddr"}, {20'd0, mem_waddr}, 0);
        chk({p, "_wdata"}, mem_wdata, 0);
        chk({p, "_be"}, {28'd0, mem_be}, 0);
        chk({p, "_done"}, {31'd0, frame_done}, 0);
        chk({p, "_cnt"}, {18'd0, byte_cnt}, 0);
        chk({p, "_gap"}, {31'd0, err_gap}, 0);
        chk({p, "_ovf"}, {31'd0, err_ovf}, 0);
    endtask

    task automatic do_reset();
        @(negedge rxclk);
        rst_n = 1'b0;
        din_vld = 1'b0;
        repeat (2) @(negedge rxclk);
        chk_rst("rst");
        rst_n = 1'b1;
        q.delete();
        n_done = 0;
    endtask

    task automatic run_seg(input int cyc, input int a0, input int n, input int k, input int j);
        for (int i = 0; i < n; i++) begin
            @(negedge rxclk);
            din_vld = 1'b1;
            cycle = 14'(cyc);
            addr = 14'((k != 0 && i >= k) ? j + i - k : a0 + i);
            din = byte_of(addr);
        end
        @(negedge rxclk);
        din_vld = 1'b0;
        repeat (3) @(negedge rxclk);
    endtask

    initial begin
        vec_t v[8];
        v[0] = '{8,   0, 8,  0, 0, 2, 0, 15, 1, 15, 0, 0,  1, 0, 0, 0};
        v[1] = '{100, 5, 6,  0, 0, 2, 1, 14, 2, 7,  0, 0,  0, 0, 0, 6};
        v[2] = '{16,  0, 4,  3, 8, 2, 0, 7,  2, 1,  0, 0,  0, 1, 0, 4};
        v[3] = '{4,   2, 4,  0, 0, 1, 0, 12, 0, 0,  0, 0,  0, 0, 1, 2};
        v[4] = '{0,   0, 6,  0, 0, 0, 0, 0,  0, 0,  0, 0,  0, 0, 1, 0};
        v[5] = '{12,  0, 12, 0, 0, 3, 0, 15, 1, 15, 2, 15, 1, 0, 0, 0};
        v[6] = '{6,   3, 3,  0, 0, 2, 0, 8,  1, 3,  0, 0,  0, 0, 0, 3};
        v[7] = '{5,   0, 5,  0, 0, 2, 0, 15, 1, 1,  0, 0,  1, 0, 0, 0};
        for (int i = 0; i < 8; i++) begin
            do_reset();
            if (v[i].nw > 0) q.push_back('{v[i].wa0, v[i].be0});
            if (v[i].nw > 1) q.push_back('{v[i].wa1, v[i].be1});
            if (v[i].nw > 2) q.push_back('{v[i].wa2, v[i].be2});
            run_seg(v[i].cyc, v[i].a0, v[i].n, v[i].k, v[i].j);
            chk($sformatf("v%0d_missing_writes", i), q.size(), 0);
            chk($sformatf("v%0d_done", i), n_done, v[i].done);
            chk($sformatf("v%0d_gap", i), {31'd0, err_gap}, v[i].gap);
            chk($sformatf("v%0d_ovf", i), {31'd0, err_ovf}, v[i].ovf);
            chk($sformatf("v%0d_cnt", i), {18'd0, byte_cnt}, v[i].cnt);
        end
        do_reset();
        q.push_back('{0, 15});
        q.push_back('{1, 15});
        for (int i = 0; i <= 8; i++) begin
            @(negedge rxclk);
            if (i > 0) begin
                chk($sformatf("a_we_%0d", i - 1), {31'd0, mem_we}, 32'((i - 1) % 4 == 3));
                chk($sformatf("a_done_%0d", i - 1), {31'd0, frame_done}, 32'(i == 8));
                chk($sformatf("a_cnt_%0d", i - 1), {18'd0, byte_cnt}, i == 8 ? 0 : i);
            end
            din_vld = i < 8;
            cycle = 14'd8;
            addr = 14'(i);
            din = byte_of(addr);
        end
        repeat (2) @(negedge rxclk);
        chk("a_missing_writes", q.size(), 0);
        do_reset();
        q.push_back('{0, 1});
        for (int i = 0; i < 3; i++) begin
            @(negedge rxclk);
            din_vld = 1'b1;
            cycle = 14'd16;
            addr = 14'(i == 0 ? 0 : i + 4);
            din = byte_of(addr);
        end
        @(negedge rxclk);
        chk("b_gap", {31'd0, err_gap}, 1);
        chk("b_cnt", {18'd0, byte_cnt}, 3);
        rst_n = 1'b0;
        din_vld = 1'b0;
        @(negedge rxclk);
        chk_rst("b_rst");
        rst_n = 1'b1;
        repeat (4) @(negedge rxclk);
        chk("b_missing_writes", q.size(), 0);
        chk("b_cnt_after", {18'd0, byte_cnt}, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
